// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the 5-stage MIPS pipeline. A Tnew scoreboard follows the
// writers in E/M/W and is checked against the Tuse of the D-stage instruction's operands.
module hazard_ctrl #(
  parameter int unsigned TNEW_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_j_l,
  input  logic       d_calc_r,
  input  logic       d_calc_i,
  input  logic       d_lui,
  input  logic       d_load,
  input  logic       d_store,
  input  logic       d_branch,
  input  logic       d_jr,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_a3,
  input  logic       d_wren,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m
);

  typedef logic [TNEW_W-1:0] tnew_t;

  logic       rs_use, rt_use;
  tnew_t      rs_tuse, rt_tuse;
  logic [4:0] rs_u, rt_u;
  logic       d_writer;
  tnew_t      d_tnew;

  logic       e_valid_q, m_valid_q, w_valid_q;
  logic [4:0] e_a3_q, m_a3_q, w_a3_q;
  tnew_t      e_tnew_q, m_tnew_q;
  logic [4:0] e_rs_q, e_rt_q, m_rt_q;

  function automatic logic hit(input logic v, input logic [4:0] a3, input logic [4:0] r);
    return v && (a3 == r) && (r != 5'd0);
  endfunction

  // A younger writer that is not ready blocks older stages from being chosen.
  function automatic logic [1:0] pick(input logic e_hit, input logic e_rdy, input logic m_hit,
                                      input logic m_rdy, input logic w_hit);
    if (e_hit) return e_rdy ? 2'd1 : 2'd0;
    if (m_hit) return m_rdy ? 2'd2 : 2'd0;
    if (w_hit) return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    rs_use  = 1'b0;
    rt_use  = 1'b0;
    rs_tuse = '0;
    rt_tuse = '0;
    if (d_branch) begin
      rs_use = 1'b1;
      rt_use = 1'b1;
    end else if (d_jr) begin
      rs_use = 1'b1;
    end else if (d_calc_r) begin
      rs_use  = 1'b1;
      rt_use  = 1'b1;
      rs_tuse = TNEW_W'(1);
      rt_tuse = TNEW_W'(1);
    end else if (d_calc_i || d_load) begin
      rs_use  = 1'b1;
      rs_tuse = TNEW_W'(1);
    end else if (d_store) begin
      rs_use  = 1'b1;
      rt_use  = 1'b1;
      rs_tuse = TNEW_W'(1);
      rt_tuse = TNEW_W'(2);
    end
  end

  // Unused operands are carried as $0 so they can never stall or forward.
  assign rs_u = rs_use ? d_rs : 5'd0;
  assign rt_u = rt_use ? d_rt : 5'd0;

  assign d_writer = d_wren && (d_calc_r || d_calc_i || d_lui || d_load || d_j_l);
  assign d_tnew   = d_load ? TNEW_W'(2) : (d_calc_r || d_calc_i || d_lui) ? TNEW_W'(1) : '0;

  assign stall =
      (hit(e_valid_q, e_a3_q, rs_u) && (e_tnew_q > rs_tuse)) ||
      (hit(m_valid_q, m_a3_q, rs_u) && (m_tnew_q > rs_tuse)) ||
      (hit(e_valid_q, e_a3_q, rt_u) && (e_tnew_q > rt_tuse)) ||
      (hit(m_valid_q, m_a3_q, rt_u) && (m_tnew_q > rt_tuse));

  assign fwd_rs_d = pick(hit(e_valid_q, e_a3_q, rs_u), e_tnew_q == '0,
                         hit(m_valid_q, m_a3_q, rs_u), m_tnew_q == '0,
                         hit(w_valid_q, w_a3_q, rs_u));
  assign fwd_rt_d = pick(hit(e_valid_q, e_a3_q, rt_u), e_tnew_q == '0,
                         hit(m_valid_q, m_a3_q, rt_u), m_tnew_q == '0,
                         hit(w_valid_q, w_a3_q, rt_u));
  assign fwd_rs_e = pick(1'b0, 1'b0, hit(m_valid_q, m_a3_q, e_rs_q), m_tnew_q == '0,
                         hit(w_valid_q, w_a3_q, e_rs_q));
  assign fwd_rt_e = pick(1'b0, 1'b0, hit(m_valid_q, m_a3_q, e_rt_q), m_tnew_q == '0,
                         hit(w_valid_q, w_a3_q, e_rt_q));
  assign fwd_rt_m = hit(w_valid_q, w_a3_q, m_rt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q <= 1'b0;
      e_a3_q    <= '0;
      e_tnew_q  <= '0;
      e_rs_q    <= '0;
      e_rt_q    <= '0;
      m_valid_q <= 1'b0;
      m_a3_q    <= '0;
      m_tnew_q  <= '0;
      m_rt_q    <= '0;
      w_valid_q <= 1'b0;
      w_a3_q    <= '0;
    end else begin
      w_valid_q <= m_valid_q;
      w_a3_q    <= m_a3_q;
      m_valid_q <= e_valid_q;
      m_a3_q    <= e_a3_q;
      m_tnew_q  <= (e_tnew_q == '0) ? '0 : e_tnew_q - TNEW_W'(1);
      m_rt_q    <= e_rt_q;
      if (stall) begin
        e_valid_q <= 1'b0;
        e_a3_q    <= '0;
        e_tnew_q  <= '0;
        e_rs_q    <= '0;
        e_rt_q    <= '0;
      end else begin
        e_valid_q <= d_writer;
        e_a3_q    <= d_a3;
        e_tnew_q  <= d_writer ? d_tnew : '0;
        e_rs_q    <= rs_u;
        e_rt_q    <= rt_u;
      end
    end
  end

endmodule
